// File: rtl/t5_lsu_pkg.sv
// t5_pkg: shared opcode/fn3 constants, FSM state encoding and access legality helper for the t5 load/store unit.
package t5_pkg;
  localparam logic [4:0] OPC_LOAD  = 5'b00000;
  localparam logic [4:0] OPC_STORE = 5'b01000;
  localparam logic [2:0] FN3_B  = 3'd0;
  localparam logic [2:0] FN3_H  = 3'd1;
  localparam logic [2:0] FN3_W  = 3'd2;
  localparam logic [2:0] FN3_BU = 3'd4;
  localparam logic [2:0] FN3_HU = 3'd5;
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;
  function automatic logic fn3_legal(input logic st, input logic [2:0] f);
    return st ? (f inside {FN3_B, FN3_H, FN3_W}) : (f inside {FN3_B, FN3_H, FN3_W, FN3_BU, FN3_HU});
  endfunction
endpackage

// File: rtl/t5_lsu_if.sv
// t5_lsu_if: single-master stb/ack data bus between the load/store unit and memory.
interface t5_lsu_if #(parameter int XLEN = 32);
  logic [XLEN-1:0] dwb_adr_o, dwb_dat_o, dwb_dat_i;
  logic [3:0] dwb_sel_o;
  logic dwb_we_o, dwb_stb_o, dwb_ack_i;
  modport master(output dwb_adr_o, dwb_dat_o, dwb_sel_o, dwb_we_o, dwb_stb_o, input dwb_ack_i, dwb_dat_i);
  modport slave(input dwb_adr_o, dwb_dat_o, dwb_sel_o, dwb_we_o, dwb_stb_o, output dwb_ack_i, dwb_dat_i);
endinterface

// File: rtl/t5_lsu_align.sv
// t5_lsu_align: byte-select generation for the issuing access and lane extraction/extension of returning load data.
module t5_lsu_align (
  input  logic [1:0]  xadr_lo,
  input  logic [2:0]  xfn3,
  input  logic [1:0]  adr,
  input  logic [2:0]  fn3,
  input  logic [31:0] dat,
  output logic [3:0]  sel,
  output logic [31:0] mlod_nxt
);
  logic [7:0] b;
  logic [15:0] h;
  logic sx;
  always_comb begin
    sel = xfn3[1:0] == 2'd0 ? 4'b0001 << xadr_lo : xfn3[1:0] == 2'd1 ? 4'b0011 << {xadr_lo[1], 1'b0} : 4'b1111;
    b = dat[{adr, 3'b000} +: 8];
    h = adr[1] ? dat[31:16] : dat[15:0];
    sx = ~fn3[2];
    mlod_nxt = fn3[1:0] == 2'd0 ? {{24{sx & b[7]}}, b} : fn3[1:0] == 2'd1 ? {{16{sx & h[15]}}, h} : dat;
  end
endmodule

// File: rtl/t5_lsu.sv
// t5_lsu: load/store unit driving a stb/ack data bus and stalling the pipeline while an access is outstanding.
// Optional bus timeout with mbus error pulse when T5_LSU_TIMEOUT_EN is defined.
module t5_lsu import t5_pkg::*; #(
  parameter int XLEN = 32,
  parameter int TOUT = 255
) (
  input  logic            sclk,
  input  logic            srst,
  input  logic            sena,
  input  logic [6:2]      xopc,
  input  logic [14:12]    xfn3,
  input  logic [XLEN-1:0] xadr,
  input  logic [XLEN-1:0] xdat,
  output logic [XLEN-1:0] mlod,
  output logic            mstall,
  output logic            mmis,
  output logic            mbus,
  t5_lsu_if.master        dwb
);
  state_e state_q, state_d;
  logic [XLEN-1:0] adr_q, adr_d, dat_q, dat_d, mlod_q, mlod_d, mlod_nxt;
  logic [3:0] sel_q, sel_d, xsel;
  logic [2:0] fn3_q, fn3_d;
  logic [1:0] alo_q, alo_d;
  logic we_q, we_d, stb_q, stb_d, mmis_q, mmis_d, mbus_q, mbus_d;
  logic xmem, mis, ok, tmo;
  t5_lsu_align u_align (
    .xadr_lo(xadr[1:0]), .xfn3(xfn3), .adr(alo_q), .fn3(fn3_q),
    .dat(dwb.dwb_dat_i), .sel(xsel), .mlod_nxt(mlod_nxt)
  );
`ifdef T5_LSU_TIMEOUT_EN
  localparam int CW = $clog2(TOUT + 1) < 8 ? 8 : $clog2(TOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = state_q == REQ && !dwb.dwb_ack_i ? cnt_q + 1'b1 : '0;
    tmo = state_q == REQ && cnt_q == CW'(TOUT - 1);
  end
  always_ff @(posedge sclk) cnt_q <= srst ? '0 : cnt_d;
`else
  assign tmo = 1'b0;
`endif
  always_comb begin
    xmem = xopc == OPC_LOAD || xopc == OPC_STORE;
    mis = (xfn3[13:12] == 2'd1 && xadr[0]) || (xfn3[13:12] == 2'd2 && xadr[1:0] != 2'd0);
    ok = xmem && fn3_legal(xopc == OPC_STORE, xfn3) && !mis;
    state_d = state_q;
    adr_d = adr_q;
    dat_d = dat_q;
    sel_d = sel_q;
    fn3_d = fn3_q;
    alo_d = alo_q;
    we_d = we_q;
    stb_d = stb_q;
    mlod_d = mlod_q;
    mmis_d = 1'b0;
    mbus_d = 1'b0;
    if (state_q == IDLE) begin
      mmis_d = xmem && !ok && sena;
      if (ok) begin
        adr_d = {xadr[XLEN-1:2], 2'b00};
        alo_d = xadr[1:0];
        dat_d = xdat;
        sel_d = xsel;
        fn3_d = xfn3;
        we_d = xopc == OPC_STORE;
        stb_d = 1'b1;
        state_d = REQ;
      end
    end else if (state_q == REQ) begin
      // ack wins over a timeout landing on the same cycle
      if (dwb.dwb_ack_i || tmo) begin
        stb_d = 1'b0;
        state_d = sena ? IDLE : DONE;
        mbus_d = !dwb.dwb_ack_i;
        mlod_d = dwb.dwb_ack_i && !we_q ? mlod_nxt : mlod_q;
      end
    end else begin
      state_d = sena ? IDLE : DONE;
    end
    mstall = (state_q == IDLE && ok) || (state_q == REQ && !dwb.dwb_ack_i);
  end
  always_ff @(posedge sclk) begin
    if (srst) begin
      state_q <= IDLE;
      adr_q <= '0;
      dat_q <= '0;
      sel_q <= 4'h0;
      fn3_q <= 3'd0;
      alo_q <= 2'd0;
      we_q <= 1'b0;
      stb_q <= 1'b0;
      mlod_q <= '0;
      mmis_q <= 1'b0;
      mbus_q <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q <= adr_d;
      dat_q <= dat_d;
      sel_q <= sel_d;
      fn3_q <= fn3_d;
      alo_q <= alo_d;
      we_q <= we_d;
      stb_q <= stb_d;
      mlod_q <= mlod_d;
      mmis_q <= mmis_d;
      mbus_q <= mbus_d;
    end
  end
  assign dwb.dwb_adr_o = adr_q;
  assign dwb.dwb_dat_o = dat_q;
  assign dwb.dwb_sel_o = sel_q;
  assign dwb.dwb_we_o = we_q;
  assign dwb.dwb_stb_o = stb_q;
  assign mlod = mlod_q;
  assign mmis = mmis_q;
  assign mbus = mbus_q;
endmodule

// File: tb/tb_t5_lsu.sv
// tb_t5_lsu: scoreboard bench for t5_lsu; load results are queued at issue and compared once the access completes.
module tb_t5_lsu;
  import t5_pkg::*;
  localparam logic [4:0] OPC_OP = 5'b00100;
`ifdef T5_LSU_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif
  logic clk = 1'b0, srst = 1'b1, sena = 1'b1;
  logic [6:2] xopc = OPC_OP;
  logic [14:12] xfn3 = 3'd0;
  logic [31:0] xadr = '0, xdat = '0, mlod;
  logic mstall, mmis, mbus;
  logic [31:0] sb[$];
  logic [31:0] mlod_m = '0;
  int n_cmp = 0, n_bad = 0;
  t5_lsu_if bus();
  t5_lsu #(.TOUT(TO)) dut (
    .sclk(clk), .srst(srst), .sena(sena), .xopc(xopc), .xfn3(xfn3), .xadr(xadr), .xdat(xdat),
    .mlod(mlod), .mstall(mstall), .mmis(mmis), .mbus(mbus), .dwb(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] ext(input logic [2:0] f, input logic [1:0] a, input logic [31:0] d);
    logic [7:0] b;
    logic [15:0] h;
    b = d[8*a +: 8];
    h = d[16*a[1] +: 16];
    case (f)
      3'd0: return {{24{b[7]}}, b};
      3'd4: return {24'h0, b};
      3'd1: return {{16{h[15]}}, h};
      3'd5: return {16'h0, h};
      default: return d;
    endcase
  endfunction
  function automatic logic [3:0] exp_sel(input logic [2:0] f, input logic [1:0] a);
    case (f[1:0])
      2'd0: return a == 2'd0 ? 4'h1 : a == 2'd1 ? 4'h2 : a == 2'd2 ? 4'h4 : 4'h8;
      2'd1: return a[1] ? 4'hC : 4'h3;
      default: return 4'hF;
    endcase
  endfunction
  task automatic access(input logic [4:0] opc, input logic [2:0] fn3, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [31:0] rd, input int waits, input int hold);
    int stalls = 0, stbs = 0;
    logic st;
    st = opc == OPC_STORE;
    xopc = opc; xfn3 = fn3; xadr = adr; xdat = dat; sena = 1'b0; bus.dwb_ack_i = 1'b0;
    if (!st) mlod_m = ext(fn3, adr[1:0], rd);
    sb.push_back(mlod_m);
    @(negedge clk);
    chk("stb_before", 32'(bus.dwb_stb_o), 0);
    stalls += int'(mstall);
    tick;
    for (int i = 0; i <= waits; i++) begin
      if (i == waits) begin
        bus.dwb_ack_i = 1'b1; bus.dwb_dat_i = rd; sena = hold == 0;
      end else bus.dwb_dat_i = ~rd;
      @(negedge clk);
      stalls += int'(mstall);
      stbs += int'(bus.dwb_stb_o);
      chk("adr", bus.dwb_adr_o, {adr[31:2], 2'b00});
      chk("sel", 32'(bus.dwb_sel_o), 32'(exp_sel(fn3, adr[1:0])));
      chk("we", 32'(bus.dwb_we_o), 32'(st));
      if (st) chk("wdat", bus.dwb_dat_o, dat);
      tick;
    end
    bus.dwb_ack_i = 1'b0;
    for (int h = 0; h < hold; h++) begin
      sena = h == hold - 1;
      @(negedge clk);
      chk("done_stb", 32'(bus.dwb_stb_o), 0);
      chk("done_stall", 32'(mstall), 0);
      tick;
    end
    xopc = OPC_OP; sena = 1'b1;
    @(negedge clk);
    chk("stalls", 32'(stalls), 32'(waits + 1));
    chk("stb_cycles", 32'(stbs), 32'(waits + 1));
    chk("mlod", mlod, sb.pop_front());
    chk("stb_after", 32'(bus.dwb_stb_o), 0);
    tick;
  endtask
  task automatic misacc(input logic [4:0] opc, input logic [2:0] fn3, input logic [31:0] adr, input logic en);
    xopc = opc; xfn3 = fn3; xadr = adr; sena = en;
    @(negedge clk);
    chk("mis_stall", 32'(mstall), 0);
    tick;
    xopc = OPC_OP; sena = 1'b1;
    @(negedge clk);
    chk("mis_pulse", 32'(mmis), 32'(en));
    chk("mis_stb", 32'(bus.dwb_stb_o), 0);
    tick;
    @(negedge clk);
    chk("mis_end", 32'(mmis), 0);
    tick;
  endtask
  initial begin
    int n;
    bus.dwb_ack_i = 1'b0; bus.dwb_dat_i = '0;
    tick; tick;
    srst = 1'b0;
    @(negedge clk);
    chk("rst_stb", 32'(bus.dwb_stb_o), 0);
    chk("rst_sel", 32'(bus.dwb_sel_o), 0);
    chk("rst_adr", bus.dwb_adr_o, 0);
    chk("rst_mlod", mlod, 0);
    chk("rst_flags", {29'd0, mmis, mbus, mstall}, 0);
    tick;
    access(OPC_LOAD, FN3_B, 32'h0000_1003, 0, 32'h8012_3456, 0, 0);
    access(OPC_LOAD, FN3_BU, 32'h0000_1003, 0, 32'h8012_3456, 0, 0);
    access(OPC_STORE, FN3_H, 32'h0000_2002, 32'hBEEF_BEEF, 32'h1111_1111, 3, 0);
    misacc(OPC_LOAD, FN3_W, 32'h0000_1001, 1'b1);
    misacc(OPC_LOAD, 3'd3, 32'h0000_1000, 1'b1);
    misacc(OPC_STORE, FN3_BU, 32'h0000_1000, 1'b1);
    misacc(OPC_STORE, FN3_H, 32'h0000_1003, 1'b0);
    access(OPC_LOAD, FN3_H, 32'h0000_0002, 0, 32'h9ABC_1234, 1, 2);
    access(OPC_LOAD, FN3_HU, 32'h0000_0000, 0, 32'h1234_F00D, 0, 0);
    access(OPC_LOAD, FN3_H, 32'h0000_0000, 0, 32'h1234_F00D, 2, 0);
    access(OPC_LOAD, FN3_W, 32'h0000_0004, 0, 32'hDEAD_C0DE, 1, 1);
    for (int a = 0; a < 4; a++) begin
      access(OPC_LOAD, FN3_B, 32'h0000_3000 + 32'(a), 0, $urandom, a % 2, 0);
      access(OPC_STORE, FN3_B, 32'h0000_3000 + 32'(a), $urandom, $urandom, 0, 0);
    end
    xopc = OPC_STORE; xfn3 = FN3_W; xadr = 32'h0000_0010; xdat = 32'hCAFE_F00D; sena = 1'b0;
    tick;
    @(negedge clk);
    chk("sw_stb", 32'(bus.dwb_stb_o), 1);
    xopc = OPC_OP; sena = 1'b1; srst = 1'b1;
    tick;
    srst = 1'b0;
    @(negedge clk);
    chk("rst_req_stb", 32'(bus.dwb_stb_o), 0);
    chk("rst_req_bus", {bus.dwb_adr_o[31:6], bus.dwb_sel_o, bus.dwb_we_o, mstall}, 0);
    chk("rst_req_dat", bus.dwb_dat_o, 0);
    chk("rst_req_mlod", mlod, 0);
    mlod_m = '0;
    bus.dwb_ack_i = 1'b1; bus.dwb_dat_i = 32'hFFFF_FFFF;
    tick;
    bus.dwb_ack_i = 1'b0;
    @(negedge clk);
    chk("late_ack_mlod", mlod, mlod_m);
    chk("late_ack_stb", 32'(bus.dwb_stb_o), 0);
    chk("mbus_idle", 32'(mbus), 0);
    tick;
`ifdef T5_LSU_TIMEOUT_EN
    access(OPC_LOAD, FN3_W, 32'h0000_0020, 0, 32'h0BAD_F00D, 0, 0);
    xopc = OPC_LOAD; xfn3 = FN3_W; xadr = 32'h0000_0008; sena = 1'b1;
    tick;
    xopc = OPC_OP;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.dwb_stb_o) break;
      n++;
      tick;
    end
    chk("tmo_stb_cycles", 32'(n), 32'(TO));
    chk("tmo_mbus", 32'(mbus), 1);
    chk("tmo_stall", 32'(mstall), 0);
    chk("tmo_mlod", mlod, mlod_m);
    tick;
    @(negedge clk);
    chk("tmo_mbus_end", 32'(mbus), 0);
`else
    n = 0;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
